// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL wrapper, the supervisor and the design it resets.
// The supervisor uses the master side; the PLL/design side uses the slave side.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       clear_counts;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [7:0] retry_count;

  modport master (
    input  pll_locked,
    input  clear_counts,
    output pll_rst,
    output rst_out,
    output ready,
    output lock_loss_count,
    output retry_count
  );

  modport slave (
    output pll_locked,
    output clear_counts,
    input  pll_rst,
    input  rst_out,
    input  ready,
    input  lock_loss_count,
    input  retry_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Turns an asynchronous PLL lock flag into a clean registered design reset,
// retrying the PLL with a reset pulse when lock never arrives.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RETRY_PULSE_CYCLES  = 8,
  parameter int CNT_W               = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  pll_lock_supervisor_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN,
    PLL_RESET
  } state_t;

  // The WAIT_LOCK cycle that first sees locked_s high already counts as one
  // stable cycle, so STABLE itself only needs LOCK_STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RETRY_PULSE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic             pll_rst_q, pll_rst_d;
  logic [7:0]       loss_q, loss_d;
  logic [7:0]       retry_q, retry_d;
  logic             loss_evt;
  logic             retry_evt;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      pll_rst_q <= 1'b0;
      loss_q    <= 8'd0;
      retry_q   <= 8'd0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      pll_rst_q <= pll_rst_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    loss_evt  = 1'b0;
    retry_evt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RESET;
          retry_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      PLL_RESET: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // RUN has no timed exit, so the counter parks there instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    pll_rst_d = (state_d == PLL_RESET);

    if (bus.clear_counts) begin
      loss_d = loss_evt ? 8'd1 : 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end

    if (bus.clear_counts) begin
      retry_d = retry_evt ? 8'd1 : 8'd0;
    end else if (retry_evt && (retry_q != 8'hFF)) begin
      retry_d = retry_q + 8'd1;
    end else begin
      retry_d = retry_q;
    end
  end

  assign bus.rst_out         = rst_out_q;
  assign bus.ready           = ready_q;
  assign bus.pll_rst         = pll_rst_q;
  assign bus.lock_loss_count = loss_q;
  assign bus.retry_count     = retry_q;

endmodule
